// File: rtl/bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg
// Shared types for the multi-master bus arbiter:
//   state_e    - transaction FSM states
//   target_e   - decoded target of the granted access
//   vdp_reg_e  - VDP register offsets inside the 32-byte window
//   idx_width  - width of a master index (at least one bit)
// ---------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAM_ACC,
        RAM_DATA,
        VDP_WAIT,
        ACK,
        RELEASE
    } state_e;

    typedef enum logic {
        TGT_RAM,
        TGT_VDP
    } target_e;

    typedef enum logic [4:0] {
        VDP_DATA = 5'h00,
        VDP_CTRL = 5'h04,
        VDP_HV   = 5'h08
    } vdp_reg_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_mm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Searches the request vector
// starting one position after 'last' and wrapping, so the most recently
// served master has the lowest priority. The pointer itself is held by the
// parent.
// Ports:
//   req   in  N    request vector
//   last  in  IW   index of the previously granted master
//   grant out IW   chosen index (0 when nothing requested)
//   valid out 1    at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          valid
);

    int pos;

    // Walk the rotation once; the first hit after 'last' wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        pos   = 0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(last) + k) % N;
            if (!valid && req[pos[IW-1:0]]) begin
                valid = 1'b1;
                grant = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_mm.sv
// ---------------------------------------------------------------------------
// bus_arbiter_mm
// Round-robin multi-master arbiter and address decoder for the shared work
// RAM and the VDP register port. One transaction in flight at a time; the
// granted master gets a registered acknowledge held for ACK_HOLD cycles and
// is not re-granted until it drops its strobe.
//
// Optional build macro: BUS_ARB_TIMEOUT_EN
//   defined   - VDP accesses abort after TIMEOUT_CYCLES without dtack,
//               completing with m_err and all-ones read data
//   undefined - VDP accesses wait forever, m_err is constant 0
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   m_req/m_we        per-master strobe and write flag
//   m_addr/m_wdata    packed per-master byte address and write data
//   m_be              packed per-master byte enables
//   m_ack/m_err       per-master acknowledge / error (error qualified by ack)
//   m_rdata           shared read data, valid while any ack is high
//   ram_*             synchronous RAM port (read data one cycle after enable)
//   vdp_*             VDP register port with active-low dtack
// ---------------------------------------------------------------------------
module bus_arbiter_mm
    import bus_arb_pkg::*;
#(
    parameter int              NUM_MASTERS    = 2,
    parameter int              AW             = 24,
    parameter int              DW             = 16,
    parameter int              RAM_AW         = 12,
    parameter logic [AW-1:0]   VDP_BASE       = 24'hC00000,
    parameter int              ACK_HOLD       = 3,
    parameter int              TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_MASTERS-1:0]      m_req,
    input  logic [NUM_MASTERS-1:0]      m_we,
    input  logic [NUM_MASTERS*AW-1:0]   m_addr,
    input  logic [NUM_MASTERS*DW-1:0]   m_wdata,
    input  logic [NUM_MASTERS*DW/8-1:0] m_be,
    output logic [NUM_MASTERS-1:0]      m_ack,
    output logic [NUM_MASTERS-1:0]      m_err,
    output logic [DW-1:0]               m_rdata,
    output logic                        ram_en,
    output logic                        ram_we,
    output logic [DW/8-1:0]             ram_be,
    output logic [RAM_AW-1:0]           ram_addr,
    output logic [DW-1:0]               ram_wdata,
    input  logic [DW-1:0]               ram_rdata,
    output logic                        vdp_sel,
    output logic                        vdp_rnw,
    output logic [4:0]                  vdp_a,
    output logic [DW/8-1:0]             vdp_be,
    output logic [DW-1:0]               vdp_di,
    input  logic [DW-1:0]               vdp_do,
    input  logic                        vdp_dtack_n
);

    localparam int BW    = DW / 8;
    localparam int IW    = idx_width(NUM_MASTERS);
    localparam int CMAX  = (ACK_HOLD > TIMEOUT_CYCLES) ? ACK_HOLD : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(CMAX + 1);

    state_e            state, state_next;
    logic [IW-1:0]     last, last_d;
    logic [IW-1:0]     gnt, gnt_d;
    logic              we_q, we_d;
    logic [CW-1:0]     cnt, cnt_d;

    logic [IW-1:0]     arb_grant;
    logic              arb_valid;
    logic              sel_we;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic [BW-1:0]     sel_be;
    target_e           sel_tgt;
    logic              ack_done;

    logic [NUM_MASTERS-1:0] m_ack_d;
    logic [DW-1:0]          m_rdata_d;
    logic                   ram_en_d, ram_we_d;
    logic [BW-1:0]          ram_be_d;
    logic [RAM_AW-1:0]      ram_addr_d;
    logic [DW-1:0]          ram_wdata_d;
    logic                   vdp_sel_d, vdp_rnw_d;
    logic [4:0]             vdp_a_d;
    logic [BW-1:0]          vdp_be_d;
    logic [DW-1:0]          vdp_di_d;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [NUM_MASTERS-1:0] m_err_d;
    logic                   timeout_hit;
    assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

    rr_arbiter #(.N(NUM_MASTERS)) u_rr (
        .req   (m_req),
        .last  (last),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Fields of the master the arbiter would pick this cycle, plus the
    // window decode; upper address bits outside the VDP compare are ignored.
    always_comb begin
        sel_we    = m_we[arb_grant];
        sel_addr  = m_addr[int'(arb_grant)*AW +: AW];
        sel_wdata = m_wdata[int'(arb_grant)*DW +: DW];
        sel_be    = m_be[int'(arb_grant)*BW +: BW];
        sel_tgt   = (sel_addr[AW-1:5] == VDP_BASE[AW-1:5]) ? TGT_VDP : TGT_RAM;
    end

    assign ack_done = (cnt == CW'(ACK_HOLD - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (arb_valid) state_next = (sel_tgt == TGT_VDP) ? VDP_WAIT : RAM_ACC;
            RAM_ACC:  state_next = RAM_DATA;
            RAM_DATA: state_next = ACK;
            VDP_WAIT: begin
                if (!vdp_dtack_n) state_next = ACK;
`ifdef BUS_ARB_TIMEOUT_EN
                else if (timeout_hit) state_next = ACK;
`endif
            end
            ACK:      if (ack_done) state_next = RELEASE;
            RELEASE:  if (!m_req[gnt]) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Next values of every registered output and of the latched request.
    // Everything holds unless the current state says otherwise.
    always_comb begin
        last_d      = last;
        gnt_d       = gnt;
        we_d        = we_q;
        cnt_d       = cnt;
        m_ack_d     = m_ack;
        m_rdata_d   = m_rdata;
        ram_en_d    = ram_en;
        ram_we_d    = ram_we;
        ram_be_d    = ram_be;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        vdp_sel_d   = vdp_sel;
        vdp_rnw_d   = vdp_rnw;
        vdp_a_d     = vdp_a;
        vdp_be_d    = vdp_be;
        vdp_di_d    = vdp_di;
`ifdef BUS_ARB_TIMEOUT_EN
        m_err_d     = m_err;
`endif
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d  = arb_grant;
                    last_d = arb_grant;
                    we_d   = sel_we;
                    cnt_d  = '0;
                    if (sel_tgt == TGT_VDP) begin
                        vdp_sel_d = 1'b1;
                        vdp_rnw_d = ~sel_we;
                        vdp_a_d   = sel_addr[4:0];
                        vdp_be_d  = sel_be;
                        vdp_di_d  = sel_wdata;
                    end else begin
                        ram_en_d    = 1'b1;
                        ram_we_d    = sel_we;
                        ram_addr_d  = sel_addr[RAM_AW:1];
                        ram_be_d    = sel_be;
                        ram_wdata_d = sel_wdata;
                    end
                end
            end
            RAM_ACC: begin
                ram_en_d = 1'b0;
                ram_we_d = 1'b0;
            end
            RAM_DATA: begin
                if (!we_q) m_rdata_d = ram_rdata;
                m_ack_d[gnt] = 1'b1;
                cnt_d        = '0;
            end
            VDP_WAIT: begin
                // A dtack on the same cycle as expiry takes precedence.
                if (!vdp_dtack_n) begin
                    vdp_sel_d = 1'b0;
                    vdp_rnw_d = 1'b1;
                    if (!we_q) m_rdata_d = vdp_do;
                    m_ack_d[gnt] = 1'b1;
                    cnt_d        = '0;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    vdp_sel_d    = 1'b0;
                    vdp_rnw_d    = 1'b1;
                    m_rdata_d    = '1;
                    m_ack_d[gnt] = 1'b1;
                    m_err_d[gnt] = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
`endif
            end
            ACK: begin
                if (ack_done) begin
                    m_ack_d = '0;
`ifdef BUS_ARB_TIMEOUT_EN
                    m_err_d = '0;
`endif
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= IW'(NUM_MASTERS - 1);
            gnt       <= '0;
            we_q      <= 1'b0;
            cnt       <= '0;
            m_ack     <= '0;
            m_rdata   <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_be    <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            vdp_sel   <= 1'b0;
            vdp_rnw   <= 1'b1;
            vdp_a     <= '0;
            vdp_be    <= '0;
            vdp_di    <= '0;
        end else begin
            last      <= last_d;
            gnt       <= gnt_d;
            we_q      <= we_d;
            cnt       <= cnt_d;
            m_ack     <= m_ack_d;
            m_rdata   <= m_rdata_d;
            ram_en    <= ram_en_d;
            ram_we    <= ram_we_d;
            ram_be    <= ram_be_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
            vdp_sel   <= vdp_sel_d;
            vdp_rnw   <= vdp_rnw_d;
            vdp_a     <= vdp_a_d;
            vdp_be    <= vdp_be_d;
            vdp_di    <= vdp_di_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // Error flags travel with the acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_err <= '0;
        else        m_err <= m_err_d;
    end
`else
    assign m_err = '0;
`endif

endmodule
